// File: rtl/color_sensor_ctrl.sv
// Colour-sensor sequencer: one configuration write burst, then periodic polling of channel data
// through a req/ack I2C transaction engine. Define COLOR_SENS_AVG_EN for a per-channel IIR filter.
module color_sensor_ctrl #(
   parameter int unsigned            NUM_CHANNELS = 3,
   parameter int unsigned            BYTES_PER_CH = 2,
   parameter logic [6:0]             DEV_ADDR     = 7'h44,
   parameter logic [7:0]             CFG_REG      = 8'h01,
   parameter int unsigned            CFG_BYTES    = 2,
   parameter logic [CFG_BYTES*8-1:0] CFG_DATA     = 16'h0D3F,
   parameter logic [7:0]             DATA_REG     = 8'h09,
   parameter int unsigned            POLL_PERIOD  = 100000,
   parameter int unsigned            MAX_RETRY    = 3,
   parameter int unsigned            TIMEOUT      = 65535
) (
   input  logic                                          clock,
   input  logic                                          reset_n,
   input  logic                                          start,
   output logic                                          txn_req,
   input  logic                                          txn_ack,
   output logic                                          txn_write,
   output logic [6:0]                                    txn_dev,
   output logic [7:0]                                    txn_reg,
   output logic [7:0]                                    txn_len,
   output logic [CFG_BYTES*8-1:0]                        txn_wdata,
   input  logic                                          rd_valid,
   input  logic [7:0]                                    rd_byte,
   input  logic                                          txn_done,
   input  logic                                          txn_nack,
   output logic [NUM_CHANNELS*BYTES_PER_CH*8-1:0]        ch_data,
   output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] dominant,
   output logic                                          sample_valid,
   output logic                                          configured,
   output logic                                          error,
   output logic [2:0]                                    state
);

   localparam int unsigned CH_W   = BYTES_PER_CH * 8;
   localparam int unsigned NB     = NUM_CHANNELS * BYTES_PER_CH;
   localparam int unsigned DATA_W = NB * 8;
   localparam int unsigned WD_W   = CFG_BYTES * 8;
   localparam int unsigned DOM_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int unsigned IDX_W  = $clog2(NB + 1);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned PER_W  = $clog2(POLL_PERIOD + 1);
   localparam int unsigned RT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CFG_REQ   = 3'd1,
      S_CFG_WAIT  = 3'd2,
      S_PERIOD    = 3'd3,
      S_POLL_REQ  = 3'd4,
      S_POLL_WAIT = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [RT_W-1:0]     retry_q;
   logic [TO_W-1:0]     to_q;
   logic [PER_W-1:0]    per_q;
   logic [IDX_W-1:0]    idx_q, rx_count;
   logic [DATA_W-1:0]   shadow_q, shadow_d, filt_c;
   logic [CH_W-1:0]     best_v;
   logic [DOM_W-1:0]    dom_c;
   logic                cfg_wait, poll_wait, byte_take, to_hit, txn_fail, txn_ok;
   logic                can_retry, start_go, poll_ack, period_end;
   logic                req_d, write_d, err_d, cfgd_d, sv_d;
   logic [6:0]          dev_d;
   logic [7:0]          reg_d, len_d;
   logic [WD_W-1:0]     wdata_d;

   assign state = state_q;

   // Transaction outcome decode; a byte arriving with txn_done is counted before the length check
   always_comb begin
      cfg_wait   = (state_q == S_CFG_WAIT);
      poll_wait  = (state_q == S_POLL_WAIT);
      byte_take  = poll_wait && rd_valid && (idx_q < IDX_W'(NB));
      shadow_d   = shadow_q;
      if (byte_take) shadow_d[int'(idx_q)*8 +: 8] = rd_byte;
      rx_count   = idx_q + IDX_W'(byte_take);
      to_hit     = (to_q == TO_W'(TIMEOUT - 1));
      txn_fail   = (cfg_wait || poll_wait) &&
                   (txn_done ? (txn_nack || (poll_wait && (rx_count != IDX_W'(NB)))) : to_hit);
      txn_ok     = (cfg_wait || poll_wait) && txn_done && !txn_fail;
      can_retry  = (retry_q < RT_W'(MAX_RETRY));
      start_go   = start && ((state_q == S_IDLE) || (state_q == S_ERROR));
      poll_ack   = (state_q == S_POLL_REQ) && txn_ack;
      period_end = (per_q >= PER_W'(POLL_PERIOD - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_ERROR: if (start) state_d = S_CFG_REQ;
         S_CFG_REQ:       if (txn_ack) state_d = S_CFG_WAIT;
         S_CFG_WAIT: begin
            if (txn_ok)        state_d = S_POLL_REQ;
            else if (txn_fail) state_d = can_retry ? S_CFG_REQ : S_ERROR;
         end
         S_PERIOD:        if (period_end) state_d = S_POLL_REQ;
         S_POLL_REQ:      if (txn_ack) state_d = S_POLL_WAIT;
         S_POLL_WAIT: begin
            if (txn_ok)        state_d = S_PERIOD;
            else if (txn_fail) state_d = can_retry ? S_POLL_REQ : S_ERROR;
         end
         default:         state_d = S_IDLE;
      endcase
   end

   // Next values of the registered control outputs, keyed on the upcoming state
   always_comb begin
      req_d   = 1'b0;
      write_d = 1'b0;
      dev_d   = '0;
      reg_d   = '0;
      len_d   = '0;
      wdata_d = '0;
      err_d   = error;
      cfgd_d  = configured;
      sv_d    = 1'b0;
      case (state_d)
         S_CFG_REQ, S_CFG_WAIT: begin
            write_d = 1'b1;
            dev_d   = DEV_ADDR;
            reg_d   = CFG_REG;
            len_d   = 8'(CFG_BYTES);
            wdata_d = CFG_DATA;
         end
         S_POLL_REQ, S_POLL_WAIT, S_PERIOD: begin
            dev_d = DEV_ADDR;
            reg_d = DATA_REG;
            len_d = 8'(NB);
         end
         default: ;
      endcase
      req_d = (state_d == S_CFG_REQ) || (state_d == S_POLL_REQ);
      if (start_go) begin
         err_d  = 1'b0;
         cfgd_d = 1'b0;
      end
      if ((state_d == S_ERROR) && (state_q != S_ERROR)) err_d = 1'b1;
      if (cfg_wait && txn_ok) cfgd_d = 1'b1;
      sv_d = poll_wait && txn_ok;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         txn_req      <= 1'b0;
         txn_write    <= 1'b0;
         txn_dev      <= '0;
         txn_reg      <= '0;
         txn_len      <= '0;
         txn_wdata    <= '0;
         error        <= 1'b0;
         configured   <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         txn_req      <= req_d;
         txn_write    <= write_d;
         txn_dev      <= dev_d;
         txn_reg      <= reg_d;
         txn_len      <= len_d;
         txn_wdata    <= wdata_d;
         error        <= err_d;
         configured   <= cfgd_d;
         sample_valid <= sv_d;
      end
   end

`ifdef COLOR_SENS_AVG_EN
   logic [DATA_W-1:0]   avg_q;
   logic                avg_loaded_q;
   logic signed [CH_W:0] diff_c, sum_c;

   // avg += (new - avg) >>> 2; the first sample after start seeds the average
   always_comb begin
      filt_c = '0;
      diff_c = '0;
      sum_c  = '0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
         diff_c = $signed({1'b0, shadow_d[i*CH_W +: CH_W]}) - $signed({1'b0, avg_q[i*CH_W +: CH_W]});
         sum_c  = $signed({1'b0, avg_q[i*CH_W +: CH_W]}) + (diff_c >>> 2);
         filt_c[i*CH_W +: CH_W] = avg_loaded_q ? sum_c[CH_W-1:0] : shadow_d[i*CH_W +: CH_W];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avg_q        <= '0;
         avg_loaded_q <= 1'b0;
      end else if (start_go) begin
         avg_loaded_q <= 1'b0;
      end else if (poll_wait && txn_ok) begin
         avg_q        <= filt_c;
         avg_loaded_q <= 1'b1;
      end
   end
`else
   assign filt_c = shadow_d;
`endif

   // Strictly-greater scan so ties resolve to the lowest channel index
   always_comb begin
      dom_c  = '0;
      best_v = filt_c[CH_W-1:0];
      for (int i = 1; i < int'(NUM_CHANNELS); i++) begin
         if (filt_c[i*CH_W +: CH_W] > best_v) begin
            best_v = filt_c[i*CH_W +: CH_W];
            dom_c  = DOM_W'(i);
         end
      end
   end

   // Period counter counts the ack cycle itself, so requests land POLL_PERIOD cycles apart
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retry_q  <= '0;
         to_q     <= '0;
         per_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         ch_data  <= '0;
         dominant <= '0;
      end else begin
         if (start_go || txn_ok)          retry_q <= '0;
         else if (txn_fail && can_retry)  retry_q <= retry_q + RT_W'(1);
         to_q     <= (cfg_wait || poll_wait) ? to_q + TO_W'(1) : '0;
         if (poll_ack)                    per_q <= PER_W'(1);
         else if (!period_end)            per_q <= per_q + PER_W'(1);
         if (poll_ack)                    idx_q <= '0;
         else if (byte_take)              idx_q <= idx_q + IDX_W'(1);
         shadow_q <= shadow_d;
         if (poll_wait && txn_ok) begin
            ch_data  <= filt_c;
            dominant <= dom_c;
         end
      end
   end

endmodule

// File: tb/tb_color_sensor_ctrl.sv
// Directed bench for color_sensor_ctrl driving a hand-scripted transaction engine.
module tb_color_sensor_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        txn_ack = 1'b0;
   logic        rd_valid = 1'b0;
   logic [7:0]  rd_byte = '0;
   logic        txn_done = 1'b0;
   logic        txn_nack = 1'b0;
   logic        txn_req, txn_write, sample_valid, configured, error;
   logic [6:0]  txn_dev;
   logic [7:0]  txn_reg, txn_len;
   logic [15:0] txn_wdata;
   logic [47:0] ch_data;
   logic [1:0]  dominant;
   logic [2:0]  state;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  n_fail   = 0;
   time t_ack    = 0;
   time t_prev   = 0;

`ifdef COLOR_SENS_AVG_EN
   localparam logic [47:0] EXP_P2     = 48'h000F_001C_0018;
   localparam logic [1:0]  EXP_P2_DOM = 2'd1;
   localparam logic [47:0] EXP_B      = 48'h0000_0000_0140;
`else
   localparam logic [47:0] EXP_P2     = 48'h0030_0010_0030;
   localparam logic [1:0]  EXP_P2_DOM = 2'd0;
   localparam logic [47:0] EXP_B      = 48'h0000_0000_0200;
`endif

   always #5 clock = ~clock;

   color_sensor_ctrl #(.POLL_PERIOD(50), .TIMEOUT(1000)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .txn_req(txn_req), .txn_ack(txn_ack), .txn_write(txn_write), .txn_dev(txn_dev),
      .txn_reg(txn_reg), .txn_len(txn_len), .txn_wdata(txn_wdata),
      .rd_valid(rd_valid), .rd_byte(rd_byte), .txn_done(txn_done), .txn_nack(txn_nack),
      .ch_data(ch_data), .dominant(dominant), .sample_valid(sample_valid),
      .configured(configured), .error(error), .state(state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (txn_req !== 1'b1 && k < 200) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_req"}, 64'(txn_req), 64'd1);
   endtask

   task automatic do_ack;
      t_ack   = $time;
      txn_ack = 1'b1;
      @(negedge clock);
      txn_ack = 1'b0;
   endtask

   task automatic do_done(input logic nack);
      txn_done = 1'b1;
      txn_nack = nack;
      @(negedge clock);
      txn_done = 1'b0;
      txn_nack = 1'b0;
   endtask

   task automatic send(input int n, input logic [47:0] bv);
      for (int k = 0; k < n; k++) begin
         rd_valid = 1'b1;
         rd_byte  = bv[k*8 +: 8];
         @(negedge clock);
      end
      rd_valid = 1'b0;
      rd_byte  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      check("rst_state", 64'(state), 64'd0);
      check("rst_req", 64'(txn_req), 64'd0);
      check("rst_dev", 64'(txn_dev), 64'd0);
      check("rst_cfgd", 64'(configured), 64'd0);
      check("rst_err", 64'(error), 64'd0);
      check("rst_ch", 64'(ch_data), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_hold", 64'(state), 64'd0);

      // configuration write
      pulse_start;
      check("cfg_state", 64'(state), 64'd1);
      wait_req("cfg");
      check("cfg_write", 64'(txn_write), 64'd1);
      check("cfg_dev", 64'(txn_dev), 64'h44);
      check("cfg_reg", 64'(txn_reg), 64'h01);
      check("cfg_len", 64'(txn_len), 64'd2);
      check("cfg_wdata", 64'(txn_wdata), 64'h0D3F);
      do_ack;
      check("cfg_wait", 64'(state), 64'd2);
      check("cfg_req_drop", 64'(txn_req), 64'd0);
      do_done(1'b0);
      check("configured", 64'(configured), 64'd1);
      check("poll_state", 64'(state), 64'd4);
      check("poll_write", 64'(txn_write), 64'd0);
      check("poll_reg", 64'(txn_reg), 64'h09);
      check("poll_len", 64'(txn_len), 64'd6);

      // first poll
      do_ack;
      t_prev = t_ack;
      check("poll_wait", 64'(state), 64'd5);
      send(6, 48'h0005_0020_0010);
      do_done(1'b0);
      check("p1_sv", 64'(sample_valid), 64'd1);
      check("p1_ch", 64'(ch_data), 64'h0005_0020_0010);
      check("p1_dom", 64'(dominant), 64'd1);
      check("p1_state", 64'(state), 64'd3);
      @(negedge clock);
      check("p1_sv_pulse", 64'(sample_valid), 64'd0);

      pulse_start;
      check("busy_start_state", 64'(state), 64'd3);
      check("busy_start_cfgd", 64'(configured), 64'd1);

      // short read then successful retry
      wait_req("p2");
      do_ack;
      check("period_1", 64'(t_ack - t_prev), 64'd500);
      send(5, 48'h0030_0010_0030);
      do_done(1'b0);
      check("short_state", 64'(state), 64'd4);
      check("short_sv", 64'(sample_valid), 64'd0);
      check("short_ch", 64'(ch_data), 64'h0005_0020_0010);
      wait_req("p2r");
      do_ack;
      send(6, 48'h0030_0010_0030);
      do_done(1'b0);
      check("p2_sv", 64'(sample_valid), 64'd1);
      check("p2_ch", 64'(ch_data), 64'(EXP_P2));
      check("p2_dom", 64'(dominant), 64'(EXP_P2_DOM));

      // four poll NACKs exhaust retries
      for (int r = 0; r < 4; r++) begin
         wait_req("pn");
         do_ack;
         do_done(1'b1);
         check("pn_state", 64'(state), (r < 3) ? 64'd4 : 64'd6);
      end
      check("pn_err", 64'(error), 64'd1);
      check("pn_ch", 64'(ch_data), 64'(EXP_P2));

      // restart; four config NACKs
      pulse_start;
      check("rs_state", 64'(state), 64'd1);
      check("rs_err", 64'(error), 64'd0);
      check("rs_cfgd", 64'(configured), 64'd0);
      for (int r = 0; r < 4; r++) begin
         wait_req("cn");
         do_ack;
         do_done(1'b1);
         check("cn_state", 64'(state), (r < 3) ? 64'd1 : 64'd6);
      end
      check("cn_err", 64'(error), 64'd1);
      pulse_start;
      check("rs2_state", 64'(state), 64'd1);
      check("rs2_err", 64'(error), 64'd0);
      wait_req("c1");
      do_ack;
      do_done(1'b1);
      check("retry_cleared", 64'(state), 64'd1);
      wait_req("c2");
      do_ack;
      do_done(1'b0);
      check("rs2_cfgd", 64'(configured), 64'd1);
      check("rs2_poll", 64'(state), 64'd4);

      // filter seed and step on ch0
      wait_req("pa");
      do_ack;
      t_prev = t_ack;
      send(6, 48'h0000_0000_0100);
      do_done(1'b0);
      check("pa_ch", 64'(ch_data), 64'h0000_0000_0100);
      check("pa_dom", 64'(dominant), 64'd0);
      wait_req("pb");
      do_ack;
      check("period_2", 64'(t_ack - t_prev), 64'd500);
      send(6, 48'h0000_0000_0200);
      do_done(1'b0);
      check("pb_ch", 64'(ch_data), 64'(EXP_B));
      check("pb_dom", 64'(dominant), 64'd0);

      // reset in the middle of a poll
      wait_req("pr");
      do_ack;
      send(3, 48'h0000_0007_0707);
      reset_n = 1'b0;
      #1;
      check("mr_state", 64'(state), 64'd0);
      check("mr_req", 64'(txn_req), 64'd0);
      check("mr_ch", 64'(ch_data), 64'd0);
      check("mr_dom", 64'(dominant), 64'd0);
      check("mr_cfgd", 64'(configured), 64'd0);
      check("mr_len", 64'(txn_len), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      send(3, 48'h0000_0007_0707);
      do_done(1'b0);
      for (int k = 0; k < 3; k++) begin
         check("mr_no_sv", 64'(sample_valid), 64'd0);
         check("mr_idle", 64'(state), 64'd0);
         @(negedge clock);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
